// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column-at-a-time drive, press/release debounce, two-digit hex history.
// A key_valid pulse follows DEBOUNCE_CYCLES stable-low clks after detection; there is no backpressure (pulse-only output).
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 4800,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_keys,
  output logic [3:0] col_keys,
  output logic [3:0] hex_R,
  output logic [3:0] hex_L,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    col_idx, col_nxt;
  logic [1:0]    row_idx, row_nxt;
  logic [CW-1:0] dwell_cnt, dwell_nxt;
  logic [CW-1:0] deb_cnt, deb_nxt;
  logic [3:0]    hex_r_q, hex_r_nxt;
  logic [3:0]    hex_l_q, hex_l_nxt;
  logic          valid_q, valid_nxt;
  logic          row_up;

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else if (!rows[3]) r = 2'd3;
    return r;
  endfunction

  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  // Only the latched row matters once a key is captured; other rows are ignored.
  assign row_up = row_keys[row_idx];

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    row_nxt   = row_idx;
    dwell_nxt = dwell_cnt;
    deb_nxt   = deb_cnt;
    hex_r_nxt = hex_r_q;
    hex_l_nxt = hex_l_q;
    valid_nxt = 1'b0;
    case (state)
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          if (row_keys != 4'hF) begin
            state_nxt = DEBOUNCE;
            row_nxt   = lowest_low(row_keys);
            deb_nxt   = '0;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_up) begin
          state_nxt = SCAN;
          col_nxt   = col_idx + 2'd1;
          dwell_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = HELD;
          valid_nxt = 1'b1;
          hex_l_nxt = hex_r_q;
          hex_r_nxt = decode_key(row_idx, col_idx);
        end else begin
          deb_nxt = deb_cnt + CW'(1);
        end
      end
      HELD: begin
        if (row_up) begin
          state_nxt = RELEASE;
          deb_nxt   = '0;
        end
      end
      RELEASE: begin
        if (!row_up) begin
          state_nxt = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = SCAN;
          col_nxt   = col_idx + 2'd1;
          dwell_nxt = '0;
        end else begin
          deb_nxt = deb_cnt + CW'(1);
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      hex_r_q   <= 4'h0;
      hex_l_q   <= 4'h0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      row_idx   <= row_nxt;
      dwell_cnt <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      hex_r_q   <= hex_r_nxt;
      hex_l_q   <= hex_l_nxt;
      valid_q   <= valid_nxt;
    end
  end

  assign col_keys  = ~(4'b0001 << col_idx);
  assign hex_R     = hex_r_q;
  assign hex_L     = hex_l_q;
  assign key_valid = valid_q;
  assign key_held  = (state == HELD) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model drives rows from the column drive; a monitor checks each key_valid pulse against a queue of expected digits.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] row_keys;
  logic [3:0] col_keys;
  logic [3:0] hex_R;
  logic [3:0] hex_L;
  logic       key_valid;
  logic       key_held;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_keys  (row_keys),
    .col_keys  (col_keys),
    .hex_R     (hex_R),
    .hex_L     (hex_L),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two physical keys; force_high models a contact bounce on key 0.
  logic       k0_vld, k1_vld, force_high;
  logic [1:0] k0_r, k0_c, k1_r, k1_c;

  always_comb begin
    row_keys = 4'hF;
    if (k0_vld && !col_keys[k0_c] && !force_high) row_keys[k0_r] = 1'b0;
    if (k1_vld && !col_keys[k1_c])                row_keys[k1_r] = 1'b0;
  end

  typedef struct packed {
    logic [3:0] hr;
    logic [3:0] hl;
    logic [3:0] col;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pulses = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (key_valid) begin
      exp_t e;
      n_pulses++;
      check("no_back_to_back_valid", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_key_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_hex_R", {28'd0, hex_R}, {28'd0, e.hr});
        check("pulse_hex_L", {28'd0, hex_L}, {28'd0, e.hl});
        check("pulse_col_keys", {28'd0, col_keys}, {28'd0, e.col});
        check("pulse_key_held", {31'd0, key_held}, 32'd1);
      end
    end
    prev_valid = key_valid;
  end

  task automatic wait_col_edge(input logic [3:0] target);
    int n;
    n = 0;
    while (col_keys == target && n < 100) begin @(negedge clk); n++; end
    while (col_keys != target && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("wait_col_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_pulse();
    int n;
    n = 0;
    @(negedge clk);
    while (!key_valid && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("wait_pulse_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_held_low();
    int n;
    n = 0;
    while (key_held && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("wait_release_timeout", 32'd1, 32'd0);
  endtask

  task automatic press0(input logic [1:0] r, input logic [1:0] c);
    k0_r = r; k0_c = c; k0_vld = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_keys"},  {28'd0, col_keys}, 32'hE);
    check({tag, "_hex_R"},     {28'd0, hex_R}, 32'd0);
    check({tag, "_hex_L"},     {28'd0, hex_L}, 32'd0);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
    check({tag, "_key_held"},  {31'd0, key_held}, 32'd0);
  endtask

  initial begin
    logic [3:0] idle_cols [4];
    idle_cols[0] = 4'b1110; idle_cols[1] = 4'b1101;
    idle_cols[2] = 4'b1011; idle_cols[3] = 4'b0111;
    reset = 1'b1; force_high = 1'b0;
    k0_vld = 1'b0; k1_vld = 1'b0;
    k0_r = 2'd0; k0_c = 2'd0; k1_r = 2'd0; k1_c = 2'd0;
    #12;
    check_reset_outputs("reset");

    // Idle scan: each column for 4 clks, wrapping back to column 0.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_col_0", {28'd0, col_keys}, {28'd0, idle_cols[0]});
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("idle_col_%0d", k), {28'd0, col_keys}, {28'd0, idle_cols[(k / 4) % 4]});
    end

    // Single press "6" (row1, col2): pulse exactly 8 clks after detection.
    wait_col_edge(4'b1011);
    press0(2'd1, 2'd2);
    exp_q.push_back('{hr: 4'h6, hl: 4'h0, col: 4'b1011});
    repeat (11) @(negedge clk);
    check("press6_no_early_pulse", {31'd0, key_valid}, 32'd0);
    @(negedge clk);
    check("press6_pulse_at_8", {31'd0, key_valid}, 32'd1);
    repeat (5) @(negedge clk);
    check("press6_col_frozen", {28'd0, col_keys}, 32'hB);
    check("press6_held", {31'd0, key_held}, 32'd1);
    k0_vld = 1'b0;
    wait_held_low();
    check("press6_resume_col3", {28'd0, col_keys}, 32'h7);

    // Bounce: 3 low clks then 1 high clk during debounce -> back to scan.
    wait_col_edge(4'b1101);
    press0(2'd2, 2'd1);
    exp_q.push_back('{hr: 4'h8, hl: 4'h6, col: 4'b1101});
    repeat (7) @(negedge clk);
    force_high = 1'b1;
    @(negedge clk);
    force_high = 1'b0;
    check("bounce_col_advanced", {28'd0, col_keys}, 32'hB);
    check("bounce_no_pulse", {31'd0, key_valid}, 32'd0);
    wait_pulse();
    k0_vld = 1'b0;
    wait_held_low();

    // Two-key sequence "5" then "A".
    exp_q.push_back('{hr: 4'h5, hl: 4'h8, col: 4'b1101});
    press0(2'd1, 2'd1);
    wait_pulse();
    k0_vld = 1'b0;
    wait_held_low();
    exp_q.push_back('{hr: 4'hA, hl: 4'h5, col: 4'b0111});
    press0(2'd0, 2'd3);
    wait_pulse();
    k0_vld = 1'b0;
    wait_held_low();
    check("seq_hex_L", {28'd0, hex_L}, 32'h5);
    check("seq_hex_R", {28'd0, hex_R}, 32'hA);

    // Hold "1", press a second row, glitch the release.
    exp_q.push_back('{hr: 4'h1, hl: 4'hA, col: 4'b1110});
    press0(2'd0, 2'd0);
    wait_pulse();
    k1_r = 2'd1; k1_c = 2'd0; k1_vld = 1'b1;
    repeat (20) @(negedge clk);
    check("held_second_key_ignored", {28'd0, hex_R}, 32'h1);
    check("held_still_held", {31'd0, key_held}, 32'd1);
    k1_vld = 1'b0;
    @(negedge clk);
    k0_vld = 1'b0;
    repeat (3) @(negedge clk);
    k0_vld = 1'b1;
    check("glitch_held", {31'd0, key_held}, 32'd1);
    repeat (12) @(negedge clk);
    check("glitch_col_frozen", {28'd0, col_keys}, 32'hE);
    check("glitch_still_held", {31'd0, key_held}, 32'd1);
    k0_vld = 1'b0;
    repeat (8) @(negedge clk);
    check("release_held_at_8", {31'd0, key_held}, 32'd1);
    @(negedge clk);
    check("release_dropped_at_9", {31'd0, key_held}, 32'd0);
    check("release_resume_col1", {28'd0, col_keys}, 32'hD);

    // Reset during DEBOUNCE with "9" held through reset.
    wait_col_edge(4'b1011);
    press0(2'd2, 2'd2);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_debounce");
    exp_q.push_back('{hr: 4'h9, hl: 4'h0, col: 4'b1011});
    @(negedge clk);
    reset = 1'b0;
    wait_pulse();
    // Reset during HELD.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_held");
    k0_vld = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_col1", {28'd0, col_keys}, 32'hD);

    repeat (10) @(negedge clk);
    check("total_pulses", n_pulses, 32'd6);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
